// File: rtl/first_match_monitor.sv
// Per-attempt framing of the first-match checker's match/fail stream: pass/timeout
// verdicts, saturating statistics, worst-case latency and sticky protocol errors.
module first_match_monitor #(
  parameter int TIMEOUT = 16,
  parameter int LAT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             match,
  input  logic             fail,
  input  logic             clear,
  output logic             busy,
  output logic             pass_pulse,
  output logic             timeout_pulse,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             overlap_err,
  output logic             stray_err,
  output logic             proto_err,
  output logic             dbg_state
);

  // Handshake: start is a single-cycle launch accepted only while busy=0;
  // match/fail are only meaningful while busy=1; anything else sets a sticky flag.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [LAT_W:0]   TMO_V   = (LAT_W+1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W:0]   lat_inc;

  assign lat_inc   = {1'b0, lat_cnt} + {1'b0, LAT_ONE};
  assign busy      = (state == S_WAIT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      lat_cnt       <= '0;
      pass_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      last_lat      <= '0;
      max_lat       <= '0;
      pass_cnt      <= '0;
      timeout_cnt   <= '0;
      overlap_err   <= 1'b0;
      stray_err     <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      pass_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (match || fail) stray_err <= 1'b1;
          if (start) begin
            state   <= S_WAIT;
            lat_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (start) overlap_err <= 1'b1;
          if (match) begin
            pass_pulse <= 1'b1;
            state      <= S_IDLE;
            if (fail) proto_err <= 1'b1;
            last_lat <= lat_cnt;
            if (lat_cnt > max_lat) max_lat <= lat_cnt;
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
          end else if (fail) begin
            if (lat_inc == TMO_V) begin
              timeout_pulse <= 1'b1;
              state         <= S_IDLE;
              if (timeout_cnt != CNT_MAX) timeout_cnt <= timeout_cnt + CNT_ONE;
            end else begin
              lat_cnt <= lat_inc[LAT_W-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // Clear overrides any same-cycle update of statistics and flags; pulses still go out.
      if (clear) begin
        last_lat    <= '0;
        max_lat     <= '0;
        pass_cnt    <= '0;
        timeout_cnt <= '0;
        overlap_err <= 1'b0;
        stray_err   <= 1'b0;
        proto_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_first_match_monitor.sv
// Bench for first_match_monitor: directed scenarios plus random traffic against an
// attempt-level reference model.
module tb_first_match_monitor;

  localparam int TMO  = 8;
  localparam int LW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst, start, match, fail, clear;
  logic          busy, pass_pulse, timeout_pulse;
  logic [LW-1:0] last_lat, max_lat;
  logic [CW-1:0] pass_cnt, timeout_cnt;
  logic          overlap_err, stray_err, proto_err, dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int n_pp_seen = 0;
  int n_tp_seen = 0;

  // reference model state
  bit m_busy, m_pp, m_tp, m_ov, m_st, m_pr;
  int m_fails, m_last, m_max, m_pass, m_tmo;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] obs_q[$];

  first_match_monitor #(.TIMEOUT(TMO), .LAT_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .match(match), .fail(fail), .clear(clear),
    .busy(busy), .pass_pulse(pass_pulse), .timeout_pulse(timeout_pulse),
    .last_lat(last_lat), .max_lat(max_lat), .pass_cnt(pass_cnt), .timeout_cnt(timeout_cnt),
    .overlap_err(overlap_err), .stray_err(stray_err), .proto_err(proto_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, let the edge happen, advance the model, record observations.
  task automatic cycle(input bit r, input bit s, input bit m, input bit f, input bit c);
    rst = r; start = s; match = m; fail = f; clear = c;
    @(posedge clk);
    #1;
    m_pp = 0; m_tp = 0;
    if (r) begin
      m_busy = 0; m_fails = 0; m_last = 0; m_max = 0; m_pass = 0; m_tmo = 0;
      m_ov = 0; m_st = 0; m_pr = 0;
    end else begin
      if (!m_busy) begin
        if (m || f) m_st = 1;
        if (s) begin m_busy = 1; m_fails = 0; end
      end else begin
        if (s) m_ov = 1;
        if (m) begin
          m_pp = 1; m_busy = 0;
          if (f) m_pr = 1;
          m_last = m_fails;
          if (m_fails > m_max) m_max = m_fails;
          m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
        end else if (f) begin
          m_fails++;
          if (m_fails == TMO) begin
            m_tp = 1; m_busy = 0;
            m_tmo = (m_tmo < CMAX) ? m_tmo + 1 : CMAX;
          end
        end
      end
      if (c) begin
        m_last = 0; m_max = 0; m_pass = 0; m_tmo = 0; m_ov = 0; m_st = 0; m_pr = 0;
      end
    end
    if (m_pp) exp_q.push_back(LW'(m_last));
    if (pass_pulse === 1'b1) begin obs_q.push_back(last_lat); n_pp_seen++; end
    if (timeout_pulse === 1'b1) n_tp_seen++;
    rst = 0; start = 0; match = 0; fail = 0; clear = 0;
  endtask

  task automatic run_attempt(input int lat);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < lat; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d want 0", busy); end
    n_checks++; if (pass_pulse !== 1'b0 || timeout_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got %0d/%0d want 0/0", pass_pulse, timeout_pulse); end
    n_checks++; if (last_lat !== 0 || max_lat !== 0) begin n_err++; $display("FAIL reset_lat: got %0d/%0d want 0/0", last_lat, max_lat); end
    n_checks++; if (pass_cnt !== 0 || timeout_cnt !== 0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", pass_cnt, timeout_cnt); end
    n_checks++; if ({overlap_err, stray_err, proto_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {overlap_err, stray_err, proto_err}); end
  endtask

  task automatic test_pass_gaps();
    int pp0;
    pp0 = n_pp_seen;
    cycle(0, 1, 0, 0, 0);
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL gaps_busy_rise: got %0d want 1", busy); end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    n_checks++; if (busy !== 1'b1 || pass_pulse !== 1'b0) begin n_err++; $display("FAIL gaps_hold: got busy=%0d pp=%0d want 1/0", busy, pass_pulse); end
    cycle(0, 0, 1, 0, 0);
    n_checks++; if (pass_pulse !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL gaps_pulse: got pp=%0d busy=%0d want 1/0", pass_pulse, busy); end
    n_checks++; if (last_lat !== 8'd3 || max_lat !== 8'd3) begin n_err++; $display("FAIL gaps_lat: got %0d/%0d want 3/3", last_lat, max_lat); end
    n_checks++; if (pass_cnt !== 4'd1) begin n_err++; $display("FAIL gaps_pass_cnt: got %0d want 1", pass_cnt); end
    cycle(0, 0, 0, 0, 0);
    n_checks++; if (pass_pulse !== 1'b0 || n_pp_seen - pp0 != 1) begin n_err++; $display("FAIL gaps_once: got pp=%0d pulses=%0d want 0/1", pass_pulse, n_pp_seen - pp0); end
  endtask

  task automatic test_timeout();
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < TMO - 1; i++) cycle(0, 0, 0, 1, 0);
    n_checks++; if (timeout_pulse !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL tmo_early: got tp=%0d busy=%0d want 0/1", timeout_pulse, busy); end
    cycle(0, 0, 0, 1, 0);
    n_checks++; if (timeout_pulse !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL tmo_pulse: got tp=%0d busy=%0d want 1/0", timeout_pulse, busy); end
    n_checks++; if (timeout_cnt !== 4'd1 || last_lat !== 8'd3) begin n_err++; $display("FAIL tmo_stats: got cnt=%0d last=%0d want 1/3", timeout_cnt, last_lat); end
    cycle(0, 0, 1, 0, 0);
    n_checks++; if (stray_err !== 1'b1 || pass_pulse !== 1'b0) begin n_err++; $display("FAIL tmo_stray: got st=%0d pp=%0d want 1/0", stray_err, pass_pulse); end
  endtask

  task automatic test_max_clear();
    cycle(0, 0, 0, 0, 1);
    run_attempt(5);
    run_attempt(2);
    run_attempt(0);
    n_checks++; if (last_lat !== 8'd0 || max_lat !== 8'd5) begin n_err++; $display("FAIL max_lat: got %0d/%0d want 0/5", last_lat, max_lat); end
    n_checks++; if (pass_cnt !== 4'd3) begin n_err++; $display("FAIL max_pass_cnt: got %0d want 3", pass_cnt); end
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1);
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy: got %0d want 1", busy); end
    n_checks++; if (pass_cnt !== 0 || timeout_cnt !== 0 || max_lat !== 0 || last_lat !== 0) begin n_err++; $display("FAIL clear_stats: got %0d %0d %0d %0d want 0 0 0 0", pass_cnt, timeout_cnt, max_lat, last_lat); end
    n_checks++; if ({overlap_err, stray_err, proto_err} !== 3'b000) begin n_err++; $display("FAIL clear_flags: got %b want 000", {overlap_err, stray_err, proto_err}); end
    cycle(0, 0, 1, 0, 0);
    n_checks++; if (last_lat !== 8'd1 || pass_cnt !== 4'd1) begin n_err++; $display("FAIL clear_keeps_lat_cnt: got last=%0d cnt=%0d want 1/1", last_lat, pass_cnt); end
  endtask

  task automatic test_saturation();
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 17; k++) run_attempt(0);
    n_checks++; if (pass_cnt !== 4'd15) begin n_err++; $display("FAIL sat_pass: got %0d want 15", pass_cnt); end
    for (int k = 0; k < 16; k++) begin
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < TMO; i++) cycle(0, 0, 0, 1, 0);
    end
    n_checks++; if (timeout_cnt !== 4'd15 || pass_cnt !== 4'd15) begin n_err++; $display("FAIL sat_tmo: got %0d/%0d want 15/15", timeout_cnt, pass_cnt); end
  endtask

  task automatic test_overlap();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    n_checks++; if (overlap_err !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL ovl_flag: got ov=%0d busy=%0d want 1/1", overlap_err, busy); end
    cycle(0, 0, 1, 0, 0);
    n_checks++; if (last_lat !== 8'd4 || pass_cnt !== 4'd1) begin n_err++; $display("FAIL ovl_result: got last=%0d cnt=%0d want 4/1", last_lat, pass_cnt); end
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    n_checks++; if (pass_pulse !== 1'b1 || busy !== 1'b0 || overlap_err !== 1'b1) begin n_err++; $display("FAIL ovl_coincident: got pp=%0d busy=%0d ov=%0d want 1/0/1", pass_pulse, busy, overlap_err); end
  endtask

  task automatic test_proto();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    n_checks++; if (proto_err !== 1'b1 || pass_pulse !== 1'b1) begin n_err++; $display("FAIL proto_flag: got pr=%0d pp=%0d want 1/1", proto_err, pass_pulse); end
    n_checks++; if (pass_cnt !== 4'd1 || last_lat !== 8'd1 || stray_err !== 1'b0) begin n_err++; $display("FAIL proto_stats: got cnt=%0d last=%0d st=%0d want 1/1/0", pass_cnt, last_lat, stray_err); end
    cycle(0, 1, 1, 0, 0);
    n_checks++; if (stray_err !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL stray_with_start: got st=%0d busy=%0d want 1/1", stray_err, busy); end
    cycle(0, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    int pp0, tp0;
    pp0 = n_pp_seen; tp0 = n_tp_seen;
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    n_checks++; if (busy !== 1'b0 || pass_cnt !== 0 || timeout_cnt !== 0 || {overlap_err, stray_err, proto_err} !== 3'b000) begin n_err++; $display("FAIL rstmid_state: got busy=%0d cnt=%0d/%0d flags=%b want 0 0/0 000", busy, pass_cnt, timeout_cnt, {overlap_err, stray_err, proto_err}); end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);
    n_checks++; if (n_pp_seen != pp0 || n_tp_seen != tp0) begin n_err++; $display("FAIL rstmid_no_pulse: got %0d/%0d extra pulses want 0/0", n_pp_seen - pp0, n_tp_seen - tp0); end
    run_attempt(2);
    n_checks++; if (last_lat !== 8'd2 || pass_cnt !== 4'd1 || max_lat !== 8'd2) begin n_err++; $display("FAIL rstmid_next: got last=%0d cnt=%0d max=%0d want 2/1/2", last_lat, pass_cnt, max_lat); end
  endtask

  task automatic test_random();
    int errs0;
    errs0 = n_err;
    exp_q.delete(); obs_q.delete();
    cycle(1, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 0, $urandom_range(0, 39) == 0);
      n_checks++;
      if (busy !== m_busy || pass_pulse !== m_pp || timeout_pulse !== m_tp) begin
        n_err++; $display("FAIL rnd_ctl @%0d: got busy/pp/tp=%0d%0d%0d want %0d%0d%0d", n, busy, pass_pulse, timeout_pulse, m_busy, m_pp, m_tp);
      end
      n_checks++;
      if (last_lat !== LW'(m_last) || max_lat !== LW'(m_max)) begin
        n_err++; $display("FAIL rnd_lat @%0d: got %0d/%0d want %0d/%0d", n, last_lat, max_lat, m_last, m_max);
      end
      n_checks++;
      if (pass_cnt !== CW'(m_pass) || timeout_cnt !== CW'(m_tmo)) begin
        n_err++; $display("FAIL rnd_cnt @%0d: got %0d/%0d want %0d/%0d", n, pass_cnt, timeout_cnt, m_pass, m_tmo);
      end
      n_checks++;
      if ({overlap_err, stray_err, proto_err} !== {m_ov, m_st, m_pr}) begin
        n_err++; $display("FAIL rnd_flags @%0d: got %b want %b", n, {overlap_err, stray_err, proto_err}, {m_ov, m_st, m_pr});
      end
      if (n_err - errs0 > 20) break;
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rnd_pass_count: got %0d passes want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rnd_pass_lat #%0d: got %0d want %0d", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; match = 1'b0; fail = 1'b0; clear = 1'b0;
    test_reset();
    test_pass_gaps();
    test_timeout();
    test_max_clear();
    test_saturation();
    test_overlap();
    test_proto();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/first_match_monitor.md
# first_match_monitor

Downstream consumer of the first-match sequence checker. It frames each attempt that the checker is enabled for, and turns the checker's raw per-cycle match/fail stream into per-attempt verdicts: pass with latency, or timeout. It also keeps saturating pass/timeout statistics, the worst-case latency, and sticky protocol-error flags for the assertion reporting logic.

## Interface
- TIMEOUT, 16, number of fail cycles in one attempt that constitutes a timeout; legal range 1..2^LAT_W-1
- LAT_W, 8, width of the latency outputs
- CNT_W, 16, width of the pass/timeout counters
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  attempt launch; the same pulse that drives the checker's en
- match  in  1  checker match output (registered, one-cycle pulse)
- fail  in  1  checker fail output (high on every waiting cycle without a match)
- clear  in  1  synchronous clear of statistics and sticky errors
- busy  out  1  attempt in progress (state WAIT)
- pass_pulse  out  1  one-cycle pulse: attempt ended with a match
- timeout_pulse  out  1  one-cycle pulse: attempt ended by timeout
- last_lat  out  LAT_W  fail-cycle count of the most recent passing attempt
- max_lat  out  LAT_W  largest last_lat since reset/clear
- pass_cnt  out  CNT_W  passing attempts, saturating
- timeout_cnt  out  CNT_W  timed-out attempts, saturating
- overlap_err  out  1  sticky: start seen while busy
- stray_err  out  1  sticky: match or fail seen while idle
- proto_err  out  1  sticky: match and fail high in the same cycle

## Operation
- FSM states are IDLE and WAIT. Internal lat_cnt is LAT_W bits wide.
- IDLE:
  - start=1 → WAIT, lat_cnt←0.
  - match or fail =1 → stray_err←1, and the input is otherwise ignored. This holds even when start is also high in the same cycle.
- WAIT, evaluated in priority order:
  1. match=1 → pass_pulse, last_lat←lat_cnt, max_lat←max(max_lat, lat_cnt), pass_cnt+1, → IDLE. If fail=1 in the same cycle, proto_err←1 and the cycle still counts as a match.
  2. fail=1 and lat_cnt+1==TIMEOUT → timeout_pulse, timeout_cnt+1, → IDLE. last_lat and max_lat are unchanged.
  3. fail=1 otherwise → lat_cnt+1, stay in WAIT.
  4. Neither → hold. lat_cnt is unchanged; gap cycles are not counted.
- A start while in WAIT sets overlap_err←1 and is otherwise ignored; the current attempt continues. A start coincident with the terminating match or timeout is also ignored and flags overlap_err. No attempt is queued.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear=1:
  - zeroes pass_cnt, timeout_cnt, max_lat, last_lat, overlap_err, stray_err and proto_err;
  - has no effect on the FSM or lat_cnt;
  - a pass or timeout in the same cycle is discarded from the counters and latency registers, but its pulse is still issued.
- rst has priority over everything. A reset mid-attempt abandons the attempt with no pulse.

## Timing
- All outputs are registered. An input sampled at edge N produces its response visible after edge N, with 1-cycle latency.
- busy rises the cycle after start is sampled in IDLE and falls in the same cycle that pass_pulse or timeout_pulse is high.
- The earliest a new attempt can be accepted is when start is sampled with busy=0, i.e. the cycle in which the terminating pulse is visible.
- The timeout pulse is visible one cycle after the TIMEOUT-th fail is sampled.
- Reset values: busy=0, pass_pulse=0, timeout_pulse=0, last_lat=0, max_lat=0, pass_cnt=0, timeout_cnt=0, all error flags=0, state=IDLE, lat_cnt=0.

## Test plan
All scenarios use TIMEOUT=8, LAT_W=8, CNT_W=4.
- Pass with gaps: start, then 3 fail cycles, 2 idle gaps, match → pass_pulse once; last_lat=3, max_lat=3, pass_cnt=1, busy low after the pulse.
- Timeout: start, then 8 consecutive fails → timeout_pulse one cycle after the 8th fail; timeout_cnt=1, last_lat unchanged. A match on the following cycle → stray_err=1.
- Max tracking: attempts with latencies 5, 2, 0 → last_lat=0, max_lat=5, pass_cnt=3. Then clear → all statistics and flags read 0 and busy is unaffected.
- Saturation: 17 passing attempts → pass_cnt stays at 15.
- Protocol errors:
  - start while busy → overlap_err=1 and the attempt's result is unchanged;
  - match&fail together in WAIT → pass counted, proto_err=1.
- Reset mid-attempt: start, 4 fails, rst → no pulse; busy=0 and all outputs at reset values. A new attempt then behaves normally with latency counted from 0.
